// File: rtl/baud_ctrl_pkg.sv
// baud_ctrl_pkg
//   Shared definitions for the UART baud-rate controller: default clock and
//   divider configuration, baud-code constants, the baud-rate table and the
//   round-to-nearest divisor function used to build the divisor lookup.
package baud_ctrl_pkg;

  localparam int unsigned DEF_CLK_FREQ_HZ = 50_000_000;
  localparam int unsigned DEF_OVERSAMPLE  = 16;
  localparam int unsigned DEF_CNT_W       = 14;

  localparam int unsigned NUM_BAUD = 8;

  typedef enum logic [2:0] {
    BAUD_300    = 3'b000,
    BAUD_1200   = 3'b001,
    BAUD_4800   = 3'b010,
    BAUD_9600   = 3'b011,
    BAUD_19200  = 3'b100,
    BAUD_38400  = 3'b101,
    BAUD_57600  = 3'b110,
    BAUD_115200 = 3'b111
  } baud_code_t;

  // Baud rate in bits/s, indexed by baud code.
  localparam int unsigned BAUD_RATE [NUM_BAUD] = '{
    300, 1200, 4800, 9600, 19200, 38400, 57600, 115200
  };

  // N = round(clk_hz / (os * baud)), integer round-to-nearest.
  function automatic int unsigned baud_divisor(
    input int unsigned clk_hz,
    input int unsigned os,
    input int unsigned baud
  );
    longint unsigned den;
    den = 64'(os) * 64'(baud);
    return 32'((64'(clk_hz) + den / 2) / den);
  endfunction

endpackage

// File: rtl/baud_divisor_lut.sv
// baud_divisor_lut
//   Combinational baud code -> (divisor - 1) lookup. The table is computed at
//   elaboration from baud_ctrl_pkg::baud_divisor; elaboration stops if any
//   divisor is below 2 or does not fit the CNT_W-bit counter.
// Ports:
//   code    in   3        baud rate code
//   div_m1  out  CNT_W    terminal count (divisor minus one) for that code
module baud_divisor_lut
  import baud_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int unsigned OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic [2:0]       code,
  output logic [CNT_W-1:0] div_m1
);

  logic [CNT_W-1:0] div_tbl [NUM_BAUD];

  for (genvar i = 0; i < NUM_BAUD; i++) begin : g_div
    localparam int unsigned N = baud_divisor(CLK_FREQ_HZ, OVERSAMPLE, BAUD_RATE[i]);

    if (N < 2 || (64'(N) - 64'd1) >= (64'd1 << CNT_W)) begin : g_bad
      $error("baud_divisor_lut: divisor %0d for code %0d out of range", N, i);
    end

    assign div_tbl[i] = CNT_W'(N - 1);
  end

  always_comb div_m1 = div_tbl[code];

endmodule

// File: rtl/baud_controller.sv
// baud_controller
//   Generates the UART oversampling strobe sample_ENABLE: a registered
//   one-clock pulse every N clocks, N picked by baud_select. A change of
//   baud_select restarts the period without emitting a partial pulse.
//   Optional macro BAUD_CTRL_BIT_TICK_EN adds bit_ENABLE, a registered pulse
//   coincident with every OVERSAMPLE-th sample_ENABLE.
// Ports:
//   clk            in   1  system clock, rising edge
//   reset          in   1  asynchronous active-low reset
//   baud_select    in   3  baud rate code (synchronous to clk)
//   sample_ENABLE  out  1  oversampling strobe
//   bit_ENABLE     out  1  bit-rate strobe (only with BAUD_CTRL_BIT_TICK_EN)
module baud_controller
  import baud_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int unsigned OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_ENABLE
`ifdef BAUD_CTRL_BIT_TICK_EN
  ,
  output logic       bit_ENABLE
`endif
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_m1;
  logic [2:0]       sel_q;
  logic             sel_vld;
  logic             sel_chg;
  logic             tc;

  baud_divisor_lut #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .OVERSAMPLE  (OVERSAMPLE),
    .CNT_W       (CNT_W)
  ) u_lut (
    .code   (baud_select),
    .div_m1 (div_m1)
  );

  // sel_q is not loaded from baud_select during reset (that would be an
  // asynchronous data load). sel_vld masks change detection on the first
  // edge after reset instead, which gives the same observable behaviour.
  always_comb begin
    sel_chg = sel_vld && (baud_select != sel_q);
    tc      = (cnt == div_m1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      sample_ENABLE <= 1'b0;
      sel_q         <= BAUD_300;
      sel_vld       <= 1'b0;
    end else begin
      sel_q   <= baud_select;
      sel_vld <= 1'b1;
      if (sel_chg) begin
        // Change wins over terminal count: the pending pulse is dropped.
        cnt           <= '0;
        sample_ENABLE <= 1'b0;
      end else if (tc) begin
        cnt           <= '0;
        sample_ENABLE <= 1'b1;
      end else begin
        cnt           <= cnt + CNT_W'(1);
        sample_ENABLE <= 1'b0;
      end
    end
  end

`ifdef BAUD_CTRL_BIT_TICK_EN
  localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE - 1);

  logic [3:0] smp_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_cnt    <= '0;
      bit_ENABLE <= 1'b0;
    end else if (sel_chg) begin
      smp_cnt    <= '0;
      bit_ENABLE <= 1'b0;
    end else if (tc) begin
      smp_cnt    <= (smp_cnt == SMP_LAST) ? '0 : smp_cnt + 4'd1;
      bit_ENABLE <= (smp_cnt == SMP_LAST);
    end else begin
      bit_ENABLE <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_baud_controller.sv
// tb_baud_controller
//   Scoreboard bench for baud_controller: expected pulse cycles are queued as
//   stimulus is applied and compared when sample_ENABLE (and bit_ENABLE when
//   BAUD_CTRL_BIT_TICK_EN is defined) is seen high.
module tb_baud_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       sample_ENABLE;
`ifdef BAUD_CTRL_BIT_TICK_EN
  logic       bit_ENABLE;
`endif

  baud_controller #(
    .CLK_FREQ_HZ (50_000_000),
    .OVERSAMPLE  (16),
    .CNT_W       (14)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .baud_select   (baud_select),
    .sample_ENABLE (sample_ENABLE)
`ifdef BAUD_CTRL_BIT_TICK_EN
    ,
    .bit_ENABLE    (bit_ENABLE)
`endif
  );

  always #10 clk = ~clk;

  // Divisors at 50 MHz, indexed by baud code.
  int unsigned div_n [8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  longint exp_q [$];
`ifdef BAUD_CTRL_BIT_TICK_EN
  longint bit_q [$];
`endif
  longint rel;

  always @(negedge clk) begin
    if (sample_ENABLE) begin
      if (exp_q.size() == 0) check("spurious_pulse", longint'(sample_ENABLE), 0);
      else check("pulse_cycle", cyc, exp_q.pop_front());
    end else if (exp_q.size() != 0 && cyc >= exp_q[0]) begin
      check("missed_pulse", longint'(sample_ENABLE), 1);
      void'(exp_q.pop_front());
    end
  end

`ifdef BAUD_CTRL_BIT_TICK_EN
  always @(negedge clk) begin
    if (bit_ENABLE) begin
      if (bit_q.size() == 0) check("spurious_bit", longint'(bit_ENABLE), 0);
      else check("bit_cycle", cyc, bit_q.pop_front());
    end else if (bit_q.size() != 0 && cyc >= bit_q[0]) begin
      check("missed_bit", longint'(bit_ENABLE), 1);
      void'(bit_q.pop_front());
    end
  end
`endif

  task automatic wait_cyc(input longint t);
    while (cyc < t) @(negedge clk);
  endtask

  // Hold reset low for 5 clocks (100 ns) with the given code, release on a
  // falling edge and record the release cycle in rel.
  task automatic pulse_reset(input logic [2:0] code);
    exp_q.delete();
`ifdef BAUD_CTRL_BIT_TICK_EN
    bit_q.delete();
`endif
    @(negedge clk);
    reset       = 1'b0;
    baud_select = code;
    repeat (5) @(negedge clk);
    check("rst_held", longint'(sample_ENABLE), 0);
    reset = 1'b1;
    rel   = cyc;
  endtask

  task automatic expect_pulses(input longint first, input longint period, input int count);
    for (int k = 0; k < count; k++) exp_q.push_back(first + k * period);
  endtask

  task automatic settle(input longint t);
    wait_cyc(t);
    check("drain", exp_q.size(), 0);
`ifdef BAUD_CTRL_BIT_TICK_EN
    check("bit_drain", bit_q.size(), 0);
`endif
  endtask

  initial begin
    reset       = 1'b0;
    baud_select = 3'd7;
    repeat (3) @(negedge clk);
    check("reset_state", longint'(sample_ENABLE), 0);

    // 115200: first pulse 27 clocks after release, period 27.
    pulse_reset(3'd7);
    expect_pulses(rel + 27, 27, 3);
    settle(rel + 3 * 27 + 2);

    // 300: four pulses within ~1 ms, none early.
    pulse_reset(3'd0);
    expect_pulses(rel + 10417, 10417, 4);
    settle(rel + 4 * 10417 + 2);

    // Sweep 110 .. 001 with a reset before each.
    for (int c = 6; c >= 1; c--) begin
      int np;
      np = (c == 1) ? 2 : 3;
      pulse_reset(3'(c));
      expect_pulses(rel + div_n[c], div_n[c], np);
      settle(rel + np * div_n[c] + 2);
    end

    // Asynchronous reset while the strobe is high, then restart.
    pulse_reset(3'd7);
    expect_pulses(rel + 27, 27, 2);
    wait_cyc(rel + 54);
    #2 reset = 1'b0;
    #1 check("async_clear", longint'(sample_ENABLE), 0);
    check("mid_drain", exp_q.size(), 0);
    pulse_reset(3'd7);
    expect_pulses(rel + 27, 27, 2);
    settle(rel + 56);

    // 111 -> 101 at cnt = 20; then 101 -> 111 exactly at terminal count.
    pulse_reset(3'd7);
    expect_pulses(rel + 27, 27, 1);
    wait_cyc(rel + 47);
    baud_select = 3'd5;
    expect_pulses(rel + 48 + 81, 81, 2);
    wait_cyc(rel + 48 + 162 + 80);
    baud_select = 3'd7;
    expect_pulses(rel + 48 + 162 + 81 + 27, 27, 2);
    settle(rel + 48 + 162 + 81 + 54 + 2);

`ifdef BAUD_CTRL_BIT_TICK_EN
    // bit_ENABLE every 432 clocks at 115200, with every 16th sample pulse.
    pulse_reset(3'd7);
    expect_pulses(rel + 27, 27, 32);
    bit_q.push_back(rel + 432);
    bit_q.push_back(rel + 864);
    settle(rel + 866);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/baud_controller.md
Name: baud_controller

Overview:
- Generates the UART oversampling strobe `sample_ENABLE` from the system clock.
- `sample_ENABLE` is a one-clock pulse at 16x the baud rate picked by the 3-bit `baud_select`.
- Feeds the UART TX/RX state machines, which advance only on `sample_ENABLE`.
- Default system clock: 50 MHz (20 ns period).

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency in Hz.
- OVERSAMPLE, 16, sample pulses per bit period.
- CNT_W, 14, divider counter width; must hold the largest divisor minus 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state while low.
- baud_select  input  3  baud rate code.
- sample_ENABLE  output  1  registered one-clock strobe at OVERSAMPLE x baud.

Behaviour:
- Baud map, with divisor N = round(CLK_FREQ_HZ / (OVERSAMPLE * baud)) and values at 50 MHz:
  - 000: 300 baud, N = 10417
  - 001: 1200 baud, N = 2604
  - 010: 4800 baud, N = 651
  - 011: 9600 baud, N = 326
  - 100: 19200 baud, N = 163
  - 101: 38400 baud, N = 81
  - 110: 57600 baud, N = 54
  - 111: 115200 baud, N = 27
- Rounding is round-to-nearest in integer arithmetic: (CLK + OVERSAMPLE*baud/2) / (OVERSAMPLE*baud).
- Divisors are computed at elaboration. Elaboration fails if any N < 2 or N-1 >= 2^CNT_W.
- State:
  - CNT_W-bit counter `cnt`.
  - registered copy `sel_q` of `baud_select`.
  - output register for `sample_ENABLE`.
- Reset (reset low, asynchronous):
  - `cnt` = 0.
  - `sample_ENABLE` = 0.
  - `sel_q` = current `baud_select`, or 000 if unknown.
- Normal operation, per clock:
  - If `cnt` == N-1: `cnt` <= 0 and `sample_ENABLE` <= 1.
  - Otherwise: `cnt` <= `cnt` + 1 and `sample_ENABLE` <= 0.
- Timing:
  - The first pulse is high during the cycle after the N-th rising edge following reset deassertion.
  - Pulses repeat with a period of exactly N clocks.
  - Each pulse is exactly one clock wide.
- `baud_select` change (`baud_select` != `sel_q`):
  - `cnt` <= 0, `sample_ENABLE` <= 0, `sel_q` <= `baud_select`.
  - A new period of the new N starts on the next edge.
  - No partial or stretched pulse is ever emitted.
  - If the change coincides with the terminal count, the pulse is suppressed.
- `baud_select` is sampled synchronously and must be stable relative to clk. No internal synchronizer.
- `sample_ENABLE` comes straight from a flop; no combinational path from inputs.
- Reset deasserted mid-period: the counter restarts from 0 and no pulse is emitted during reset.

Optional Feature:
- Macro: BAUD_CTRL_BIT_TICK_EN.
- Defined:
  - Adds output port `bit_ENABLE` (1 bit, registered).
  - Adds a 4-bit sample counter that increments on each `sample_ENABLE`.
  - `bit_ENABLE` pulses high in the same cycle as every OVERSAMPLE-th `sample_ENABLE`, i.e. the 16th, 32nd, ... pulse after reset or a baud change.
  - The sample counter clears on reset and on a `baud_select` change.
- Undefined: port and logic absent; `sample_ENABLE` behaviour identical.

Decomposition:
- Package `baud_ctrl_pkg`:
  - baud code constants (BAUD_300 ... BAUD_115200 for codes 000..111).
  - baud rate table.
  - divisor-rounding function.
  - default CLK_FREQ_HZ, OVERSAMPLE and CNT_W.
- One natural sub-module, `baud_divisor_lut`: combinational code -> N-1 lookup built from the package function.
- The counter and strobe logic stay in `baud_controller`.

Test Plan:
- `baud_select` = 111, reset pulsed low 100 ns -> first `sample_ENABLE` 27 clocks after release, then every 27 clocks (540 ns), each pulse 20 ns wide.
- `baud_select` = 000 -> pulses every 10417 clocks (208.34 us); count pulses over 1 ms = 4 or 5, none early.
- Sweep codes 110..001 with a reset before each -> measured periods 54, 81, 163, 326, 651, 2604 clocks respectively.
- Assert reset mid-period at 115200 -> `sample_ENABLE` goes 0 immediately (asynchronous); after release the next pulse is exactly 27 clocks later.
- Change `baud_select` 111 -> 101 at `cnt` = 20 without reset -> no pulse at the old terminal count; next pulse 81 clocks after the change edge.
- With BAUD_CTRL_BIT_TICK_EN at 111 -> `bit_ENABLE` every 432 clocks, coincident with every 16th `sample_ENABLE`.
